// File: rtl/spi_cmd_pkg.sv
// spi_cmd_pkg: shared constants and types for the SPI command sender.
// Frame layout is {addr[3:0], data[11:0]}, sent MSB first.
package spi_cmd_pkg;

  localparam int FRAME_WIDTH = 16;
  localparam int ADDR_WIDTH  = 4;
  localparam int DATA_WIDTH  = 12;

  localparam logic [ADDR_WIDTH-1:0] ADDR_PWM0   = 4'd0;
  localparam logic [ADDR_WIDTH-1:0] ADDR_PWM1   = 4'd1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_PWM2   = 4'd2;
  localparam logic [ADDR_WIDTH-1:0] ADDR_PWM3   = 4'd3;
  localparam logic [ADDR_WIDTH-1:0] ADDR_PWM4   = 4'd4;
  localparam logic [ADDR_WIDTH-1:0] ADDR_PWM5   = 4'd5;
  localparam logic [ADDR_WIDTH-1:0] ADDR_PWM6   = 4'd6;
  localparam logic [ADDR_WIDTH-1:0] ADDR_PWM7   = 4'd7;
  localparam logic [ADDR_WIDTH-1:0] ADDR_CLKDIV = 4'd8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD,
    S_HIGH,
    S_LOW,
    S_TRAIL,
    S_GAP
  } state_t;

  function automatic logic [FRAME_WIDTH-1:0] pack_frame(
    input logic [ADDR_WIDTH-1:0] addr,
    input logic [DATA_WIDTH-1:0] data
  );
    return {addr, data};
  endfunction

endpackage

// File: rtl/spi_cmd_sender_if.sv
// spi_cmd_sender_if: host-side valid/ready command port.
// The host (master) offers a command; the sender (slave) accepts it.
interface spi_cmd_sender_if
  import spi_cmd_pkg::*;
#(
  parameter int CLK_DIV_WIDTH = 4
);

  logic                     cmd_valid;
  logic                     cmd_ready;
  logic [ADDR_WIDTH-1:0]    cmd_addr;
  logic [DATA_WIDTH-1:0]    cmd_data;
  logic [CLK_DIV_WIDTH-1:0] sck_div;

  modport master (
    output cmd_valid,
    output cmd_addr,
    output cmd_data,
    output sck_div,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_addr,
    input  cmd_data,
    input  sck_div,
    output cmd_ready
  );

endinterface

// File: rtl/spi_half_period_timer.sv
// spi_half_period_timer: loadable down-counter for one SCK phase.
// Loading div gives expire in the div+1'th cycle after the load.
module spi_half_period_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W:0] cnt;

  // reload at each phase start, otherwise count down to zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= {1'b0, load_val};
    end else if (cnt != '0) begin
      cnt <= cnt - (W+1)'(1);
    end
  end

  assign expire = (cnt == '0);

endmodule

// File: rtl/spi_cmd_sender.sv
// spi_cmd_sender: mode-0 SPI initiator for 16-bit command frames.
// Define SPI_CMD_QUEUE_EN for a one-entry command holding register.
module spi_cmd_sender
  import spi_cmd_pkg::*;
#(
  parameter int CLK_DIV_WIDTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  spi_cmd_sender_if.slave   cmd,
  output logic              spi_cs_n,
  output logic              spi_sck,
  output logic              spi_mosi,
  output logic              busy,
  output logic              done
);

  localparam int W = CLK_DIV_WIDTH;

  state_t                 state, state_nxt;
  logic [FRAME_WIDTH-1:0] sh, sh_nxt, src_frame;
  logic [4:0]             bit_cnt, bit_nxt;
  logic [W-1:0]           div, div_nxt, src_div;
  logic [W-1:0]           load_val;
  logic                   load, expire;
  logic                   start_in, start_hold, start;
  logic                   cs_d, sck_d, mosi_d, done_d;

`ifdef SPI_CMD_QUEUE_EN
  logic                  hold_full;
  logic [ADDR_WIDTH-1:0] hold_addr;
  logic [DATA_WIDTH-1:0] hold_data;
  logic [W-1:0]          hold_div;

  assign cmd.cmd_ready = ~hold_full;
  assign start_hold    = (state == S_IDLE) && hold_full;
  assign start_in      = (state == S_IDLE) && !hold_full
                         && cmd.cmd_valid;
  assign src_frame     = start_hold
                         ? pack_frame(hold_addr, hold_data)
                         : pack_frame(cmd.cmd_addr, cmd.cmd_data);
  assign src_div       = start_hold ? hold_div : cmd.sck_div;

  // park a command offered while a frame is in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_full <= 1'b0;
      hold_addr <= '0;
      hold_data <= '0;
      hold_div  <= '0;
    end else if (cmd.cmd_valid && !hold_full
                 && state != S_IDLE) begin
      hold_full <= 1'b1;
      hold_addr <= cmd.cmd_addr;
      hold_data <= cmd.cmd_data;
      hold_div  <= cmd.sck_div;
    end else if (start_hold) begin
      hold_full <= 1'b0;
    end
  end
`else
  assign cmd.cmd_ready = (state == S_IDLE);
  assign start_hold    = 1'b0;
  assign start_in      = (state == S_IDLE) && cmd.cmd_valid;
  assign src_frame     = pack_frame(cmd.cmd_addr, cmd.cmd_data);
  assign src_div       = cmd.sck_div;
`endif

  assign start = start_in || start_hold;
  assign busy  = (state != S_IDLE);

  spi_half_period_timer #(.W(W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .expire   (expire)
  );

  // state, shift register, bit count and latched divider
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      sh      <= '0;
      bit_cnt <= '0;
      div     <= '0;
    end else begin
      state   <= state_nxt;
      sh      <= sh_nxt;
      bit_cnt <= bit_nxt;
      div     <= div_nxt;
    end
  end

  // phase sequencing; every phase change reloads the timer
  always_comb begin
    state_nxt = state;
    sh_nxt    = sh;
    bit_nxt   = bit_cnt;
    div_nxt   = div;
    load      = 1'b0;
    load_val  = div;
    done_d    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_LEAD;
          sh_nxt    = src_frame;
          div_nxt   = src_div;
          bit_nxt   = '0;
          load      = 1'b1;
          load_val  = src_div;
        end
      end
      S_LEAD: begin
        if (expire) begin
          state_nxt = S_HIGH;
          load      = 1'b1;
        end
      end
      S_HIGH: begin
        if (expire) begin
          load    = 1'b1;
          bit_nxt = bit_cnt + 5'd1;
          if (bit_cnt == 5'd15) begin
            state_nxt = S_TRAIL;
          end else begin
            state_nxt = S_LOW;
            sh_nxt    = {sh[FRAME_WIDTH-2:0], 1'b0};
          end
        end
      end
      S_LOW: begin
        if (expire) begin
          state_nxt = S_HIGH;
          load      = 1'b1;
        end
      end
      S_TRAIL: begin
        if (expire) begin
          state_nxt = S_GAP;
          load      = 1'b1;
          done_d    = 1'b1;
        end
      end
      S_GAP: begin
        if (expire) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // pin values for the coming cycle, decoded from next state
  always_comb begin
    cs_d   = 1'b1;
    sck_d  = 1'b0;
    mosi_d = 1'b0;
    unique case (state_nxt)
      S_LEAD, S_LOW, S_TRAIL: begin
        cs_d   = 1'b0;
        mosi_d = sh_nxt[FRAME_WIDTH-1];
      end
      S_HIGH: begin
        cs_d   = 1'b0;
        sck_d  = 1'b1;
        mosi_d = sh_nxt[FRAME_WIDTH-1];
      end
      default: begin
        cs_d   = 1'b1;
      end
    endcase
  end

  // registered SPI pins and done pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spi_cs_n <= 1'b1;
      spi_sck  <= 1'b0;
      spi_mosi <= 1'b0;
      done     <= 1'b0;
    end else begin
      spi_cs_n <= cs_d;
      spi_sck  <= sck_d;
      spi_mosi <= mosi_d;
      done     <= done_d;
    end
  end

endmodule

// File: tb/tb_spi_cmd_sender.sv
// tb_spi_cmd_sender: vector table, corner sequences and random frames
// checked against a pin-level monitor and an arithmetic frame model.
module tb_spi_cmd_sender;
  import spi_cmd_pkg::*;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic spi_cs_n, spi_sck, spi_mosi, busy, done;

  spi_cmd_sender_if #(.CLK_DIV_WIDTH(W)) cif ();

  spi_cmd_sender #(.CLK_DIV_WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd      (cif),
    .spi_cs_n (spi_cs_n),
    .spi_sck  (spi_sck),
    .spi_mosi (spi_mosi),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int word;
    int nbits;
    int cslow;
    int hi_min;
    int hi_max;
    int lo_min;
    int lo_max;
    int done_end;
    int glitch;
    int gap_before;
  } rec_t;

  typedef struct {
    logic [3:0]  a;
    logic [11:0] d;
    int          div;
    int          exp_word;
    int          exp_cs;
  } vec_t;

  rec_t frames[$];
  int   done_total = 0;
  int   idle_bad   = 0;
  int   frames_exp = 0;
  int   checks     = 0;
  int   errors     = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // what a frame must look like on the wire
  function automatic void model(input int a, input int d, input int div,
                                output int word, output int cs);
    word = a * 4096 + d;
    cs   = 33 * (div + 1);
  endfunction

  // pin monitor: one record per completed chip-select window
  initial begin
    rec_t r;
    int   run, gap;
    bit   in_frame, psck, pmosi;
    r = '{default: 0};
    run = 0; gap = 0; in_frame = 0; psck = 0; pmosi = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_frame = 0; gap = 0; run = 0; psck = 0; pmosi = 0;
      end else begin
        if (!spi_cs_n) begin
          if (!in_frame) begin
            in_frame = 1;
            r = '{default: 0};
            r.hi_min = 1 << 30;
            r.lo_min = 1 << 30;
            r.gap_before = gap;
            run = 0;
          end
          if (spi_sck != psck && run > 0) begin
            if (psck) begin
              r.hi_min = (run < r.hi_min) ? run : r.hi_min;
              r.hi_max = (run > r.hi_max) ? run : r.hi_max;
            end else begin
              r.lo_min = (run < r.lo_min) ? run : r.lo_min;
              r.lo_max = (run > r.lo_max) ? run : r.lo_max;
            end
            run = 0;
          end
          run++;
          r.cslow++;
          if (spi_sck && !psck) begin
            r.word = (r.word << 1) | int'(spi_mosi);
            r.nbits++;
          end
          if (spi_sck && psck && spi_mosi != pmosi) r.glitch++;
          gap = 0;
        end else begin
          if (in_frame) begin
            r.lo_min = (run < r.lo_min) ? run : r.lo_min;
            r.lo_max = (run > r.lo_max) ? run : r.lo_max;
            r.done_end = int'(done);
            frames.push_back(r);
            in_frame = 0;
            run = 0;
          end
          if (spi_sck || spi_mosi) idle_bad++;
          gap++;
        end
        if (done) done_total++;
        psck = spi_sck;
        pmosi = spi_mosi;
      end
    end
  end

  task automatic accept(input logic [3:0] a, input logic [11:0] d,
                        input int div, input bit keep, output bit ok);
    @(negedge clk);
    cif.cmd_valid = 1'b1;
    cif.cmd_addr  = a;
    cif.cmd_data  = d;
    cif.sck_div   = div[W-1:0];
    ok = 0;
    for (int i = 0; i < 4000; i++) begin
      if (cif.cmd_ready) begin
        @(posedge clk);
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    chk("accept", int'(ok), 1);
    #1;
    if (!keep) begin
      cif.cmd_valid = 1'b0;
      cif.cmd_addr  = 4'($urandom);
      cif.cmd_data  = 12'($urandom);
      cif.sck_div   = W'($urandom);
    end
  endtask

  task automatic get_frame(input int ew, input int ecs, input int h,
                           output rec_t r);
    int n;
    n = 0;
    while (frames.size() == 0 && n < 6000) begin
      @(negedge clk);
      n++;
    end
    chk("frame_seen", int'(frames.size() > 0), 1);
    r = '{default: 0};
    if (frames.size() > 0) begin
      r = frames.pop_front();
      frames_exp++;
      chk("word", r.word, ew);
      chk("nbits", r.nbits, 16);
      chk("cs_low_cycles", r.cslow, ecs);
      chk("sck_high_min", r.hi_min, h);
      chk("sck_high_max", r.hi_max, h);
      chk("sck_low_min", r.lo_min, h);
      chk("sck_low_max", r.lo_max, h);
      chk("done_at_gap", r.done_end, 1);
      chk("mosi_stable_high", r.glitch, 0);
    end
  endtask

  task automatic send(input logic [3:0] a, input logic [11:0] d,
                      input int div, input int ew, input int ecs);
    rec_t r;
    bit   ok;
    accept(a, d, div, 0, ok);
    if (ok) begin
      @(negedge clk);
      chk("cs_fall_latency", int'(spi_cs_n), 0);
      chk("first_bit", int'(spi_mosi), (ew >> 15) & 1);
      chk("busy_in_frame", int'(busy), 1);
      get_frame(ew, ecs, div + 1, r);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[6];
    rec_t ra, rb;
    bit   ok, ok2;
    int   n, dt, rdy, ew, ecs;
    bit   p;

    tbl[0] = '{4'h3, 12'h2A5, 0,  'h32A5, 33};
    tbl[1] = '{4'h8, 12'h00A, 3,  'h800A, 132};
    tbl[2] = '{4'hF, 12'hFFF, 1,  'hFFFF, 66};
    tbl[3] = '{4'h0, 12'h000, 0,  'h0000, 33};
    tbl[4] = '{4'h9, 12'h555, 15, 'h9555, 528};
    tbl[5] = '{4'h7, 12'h3FF, 2,  'h73FF, 99};

    cif.cmd_valid = 1'b0;
    cif.cmd_addr  = '0;
    cif.cmd_data  = '0;
    cif.sck_div   = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cs_n", int'(spi_cs_n), 1);
    chk("rst_sck", int'(spi_sck), 0);
    chk("rst_busy", int'(busy), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_cs_n", int'(spi_cs_n), 1);
    chk("idle_sck", int'(spi_sck), 0);
    chk("idle_mosi", int'(spi_mosi), 0);
    chk("idle_busy", int'(busy), 0);
    chk("idle_done", int'(done), 0);
    chk("idle_ready", int'(cif.cmd_ready), 1);

    for (int i = 0; i < 6; i++) begin
      send(tbl[i].a, tbl[i].d, tbl[i].div,
           tbl[i].exp_word, tbl[i].exp_cs);
    end

    // divider change after acceptance only affects the next frame
    accept(4'h3, 12'h2A5, 0, 0, ok);
    cif.sck_div = 4'd7;
    get_frame('h32A5, 33, 1, ra);
    send(4'h8, 12'h0FF, 7, 'h80FF, 264);

`ifndef SPI_CMD_QUEUE_EN
    // command held valid while busy waits for the gap to end
    accept(4'h1, 12'h234, 1, 1, ok);
    cif.cmd_addr = 4'hC;
    cif.cmd_data = 12'hABC;
    rdy = 0;
    repeat (20) begin
      @(negedge clk);
      if (cif.cmd_ready) rdy++;
    end
    chk("ready_low_while_busy", rdy, 0);
    accept(4'hC, 12'hABC, 1, 0, ok2);
    get_frame('h1234, 66, 2, ra);
    get_frame('hCABC, 66, 2, rb);
    chk("held_gap_cycles", rb.gap_before, 3);
`else
    // second command queued while the first is on the wire
    accept(4'h1, 12'h111, 1, 0, ok);
    accept(4'h7, 12'hFFF, 1, 0, ok2);
    chk("busy_at_queue_accept", int'(busy), 1);
    get_frame('h1111, 66, 2, ra);
    get_frame('h7FFF, 66, 2, rb);
    chk("queued_gap_cycles", rb.gap_before, 3);
`endif

    // reset during the 8th high phase aborts the frame
    accept(4'h5, 12'h0F0, 0, 0, ok);
    n = 0;
    p = 0;
    for (int i = 0; i < 200 && n < 8; i++) begin
      @(negedge clk);
      if (spi_sck && !p) n++;
      p = spi_sck;
    end
    chk("reached_8th_high", n, 8);
    chk("sck_high_before_rst", int'(spi_sck), 1);
    dt = done_total;
    #1 rst = 1'b1;
    #1;
    chk("async_rst_cs_n", int'(spi_cs_n), 1);
    chk("async_rst_sck", int'(spi_sck), 0);
    chk("async_rst_mosi", int'(spi_mosi), 0);
    chk("async_rst_busy", int'(busy), 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    chk("no_done_after_rst", done_total, dt);
    chk("no_frame_after_rst", frames.size(), 0);
    chk("ready_after_rst", int'(cif.cmd_ready), 1);
    model(4'hA, 12'h5C3, 2, ew, ecs);
    send(4'hA, 12'h5C3, 2, ew, ecs);

    for (int i = 0; i < 16; i++) begin
      int a, d, div;
      a   = $urandom_range(0, 15);
      d   = $urandom_range(0, 4095);
      div = $urandom_range(0, 3);
      model(a, d, div, ew, ecs);
      send(4'(a), 12'(d), div, ew, ecs);
    end

    repeat (10) @(negedge clk);
    chk("done_count", done_total, frames_exp);
    chk("idle_pins_quiet", idle_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_cmd_sender.md
# spi_cmd_sender

SPI initiator that serialises 16-bit command frames (4-bit device address, 12-bit payload) onto a chip-select/clock/data triplet. It is the controller end of the command link consumed by the PWM/clock-divider target: address 0–7 selects a PWM channel, 8 the clock divider, and data bits [9:0] / [3:0] carry the compare or divider value. The block sits behind a host-side valid/ready command port, e.g. a sequencer or test harness driving a target board.

## Interface
Parameters:
- `CLK_DIV_WIDTH`, 4: width of `sck_div`; SCK half-period H = `sck_div`+1 clk cycles, range 1..2^CLK_DIV_WIDTH.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  command accepted when `cmd_valid` && `cmd_ready` at a rising edge.
- `cmd_addr`  in  4  device address, frame bits [15:12].
- `cmd_data`  in  12  payload, frame bits [11:0].
- `sck_div`  in  CLK_DIV_WIDTH  half-period select, latched at acceptance.
- `spi_cs_n`  out  1  chip select, active low.
- `spi_sck`  out  1  serial clock, idle low.
- `spi_mosi`  out  1  serial data, MSB first.
- `busy`  out  1  high while a frame or inter-frame gap is in progress.
- `done`  out  1  one-cycle pulse when a frame completes.

## Operation
- SPI mode 0: SCK idles low; target samples MOSI on SCK rising edge; MOSI changes only while SCK is low.
- Frame = {`cmd_addr`, `cmd_data`}, 16 bits, MSB first; captured into shift register at acceptance together with `sck_div`.
- States: IDLE -> LEAD -> HIGH <-> LOW -> TRAIL -> GAP -> IDLE.
  - IDLE: `cs_n`=1, `sck`=0, `mosi`=0; `cmd_ready`=1.
  - LEAD (H cycles): `cs_n`=0, `mosi`=bit 15, `sck`=0.
  - HIGH (H cycles): `sck`=1. After the 16th HIGH go to TRAIL, else LOW.
  - LOW (H cycles): `sck`=0, `mosi` = next bit from first cycle of LOW.
  - TRAIL (H cycles): `sck`=0, `cs_n`=0, `mosi` holds bit 0.
  - GAP (H cycles): `cs_n`=1, `mosi`=0; `done` pulses in first GAP cycle.
- Bit counter 5 bits, counts HIGH phases 0..15; half-period counter CLK_DIV_WIDTH+1 bits, reloads each phase.
- `busy` = state != IDLE.
- `cmd_valid` while `cmd_ready`=0 is ignored; host holds the command. `cmd_addr`/`cmd_data`/`sck_div` changes after acceptance have no effect on the frame in flight.
- Addresses 9–15 are sent unchanged; no filtering.
- `rst` mid-frame: all outputs to reset values immediately (asynchronous), frame discarded, no `done`.

## Timing
- Reset values: `spi_cs_n`=1, `spi_sck`=0, `spi_mosi`=0, `busy`=0, `done`=0, `cmd_ready`=1.
- Acceptance at edge t: `cs_n` falls and bit 15 valid at t+1.
- `cs_n` low for exactly 33·H cycles (LEAD H + 16 HIGH + 15 LOW + TRAIL H).
- `done` asserted in cycle t+1+33·H; `cs_n` high for at least H cycles before next frame.
- Without queue: `cmd_ready` returns high at t+1+34·H; next frame earliest `cs_n` fall at t+2+34·H.
- All outputs registered; no combinational path from inputs to SPI pins.

## Configuration
- `SPI_CMD_QUEUE_EN` defined: one-entry holding register (addr, data, sck_div). `cmd_ready` = holding register empty, independent of state. A queued command starts in the cycle after GAP ends, so frames are separated by exactly H cycles of `cs_n` high plus one IDLE cycle; `busy` stays high across back-to-back frames except that IDLE cycle.
- Not defined: no holding register; `cmd_ready` = (state == IDLE).

## Structure
- Package `spi_cmd_pkg`: FRAME_WIDTH=16, ADDR_WIDTH=4, DATA_WIDTH=12, address constants ADDR_PWM0..ADDR_PWM7 (0–7), ADDR_CLKDIV (8), state enum type.
- Sub-module `spi_half_period_timer`: loadable down-counter, emits one-cycle `expire` after H cycles; reused per phase.

## Test plan
- addr=3, data=0x2A5, sck_div=0 -> MOSI sampled on 16 SCK rises = 0x32A5; `cs_n` low 33 cycles; single `done`.
- sck_div=3, addr=8, data=0x00A -> every SCK phase 4 clk; `cs_n` low 132 cycles; sampled word 0x800A.
- `cmd_valid` held with new data while busy (no queue) -> `cmd_ready`=0, no second frame until GAP ends; frame in flight unchanged.
- `SPI_CMD_QUEUE_EN`, two commands 0x1111/0x7FFF, sck_div=1 -> second accepted while busy; `cs_n` high exactly 3 cycles between frames; two `done` pulses.
- `rst` pulsed during 8th HIGH phase -> `cs_n`=1, `sck`=0 same cycle; no `done`; next command transmits correctly.
- `sck_div` changed 0->7 mid-frame -> current frame keeps H=1; next frame uses H=8.
